// File: rtl/cnn_layer_accel_wht_pingpong_table_if.sv
// Config, job-control and CE read signals of the ping-pong weight table.
// master = config/CE side, slave = weight table.
interface cnn_layer_accel_wht_pingpong_table_if #(
    parameter int C_WEIGHT_WIDTH = 16,
    parameter int C_NUM_LANES    = 2,
    parameter int C_MAX_KERNELS  = 32
);
    localparam int KW = $clog2(C_MAX_KERNELS);

    logic                                  cfg_wren;
    logic [C_WEIGHT_WIDTH-1:0]             cfg_data;
    logic                                  cfg_krnl_1x1;
    logic [KW-1:0]                         cfg_num_kernels;
    logic                                  cfg_start;
    logic                                  cfg_busy;
    logic                                  cfg_err;
    logic [1:0]                            bank_full;
    logic                                  job_accept;
    logic                                  job_reject;
    logic                                  ce_execute;
    logic                                  next_kernel;
    logic [4*C_NUM_LANES-1:0]              seq_addr;
    logic [C_WEIGHT_WIDTH*C_NUM_LANES-1:0] wht_dout;
    logic                                  wht_dout_valid;
    logic                                  last_kernel;

    modport master (
        output cfg_wren, cfg_data, cfg_krnl_1x1, cfg_num_kernels, cfg_start,
        output job_accept, ce_execute, next_kernel, seq_addr,
        input  cfg_busy, cfg_err, bank_full, job_reject,
        input  wht_dout, wht_dout_valid, last_kernel
    );

    modport slave (
        input  cfg_wren, cfg_data, cfg_krnl_1x1, cfg_num_kernels, cfg_start,
        input  job_accept, ce_execute, next_kernel, seq_addr,
        output cfg_busy, cfg_err, bank_full, job_reject,
        output wht_dout, wht_dout_valid, last_kernel
    );
endinterface

// File: rtl/cnn_layer_accel_wht_pingpong_table.sv
// Double-buffered CE weight table: config fills the idle bank while the CE reads the active one.
// Read latency C_SEQ_ADDR_DELAY + C_RD_LATENCY (needs >=1 and >=2); no backpressure, one word per lane per read.
module cnn_layer_accel_wht_pingpong_table #(
    parameter int C_WEIGHT_WIDTH   = 16,
    parameter int C_NUM_LANES      = 2,
    parameter int C_MAX_KERNELS    = 32,
    parameter int C_SEQ_ADDR_DELAY = 3,
    parameter int C_RD_LATENCY     = 3
) (
    input  logic clk_core,
    input  logic rst,
    cnn_layer_accel_wht_pingpong_table_if.slave wt
);
    localparam int KW    = $clog2(C_MAX_KERNELS);
    localparam int LW    = (C_NUM_LANES > 1) ? $clog2(C_NUM_LANES) : 1;
    localparam int AW    = 1 + KW + 4;
    localparam int DEPTH = 2 * C_MAX_KERNELS * 16;
    localparam int DW    = C_WEIGHT_WIDTH * C_NUM_LANES;
    localparam int SD    = C_SEQ_ADDR_DELAY;
    localparam int RL    = C_RD_LATENCY;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_LOADING,
        BANK_FULL,
        BANK_ACTIVE
    } bank_state_e;

    bank_state_e   bank_q [2];
    bank_state_e   bank_d [2];
    logic          desc_1x1_q [2];
    logic          desc_1x1_d [2];
    logic [KW-1:0] desc_nk_q [2];
    logic [KW-1:0] desc_nk_d [2];

    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          reject_q, reject_d;
    logic [3:0]    w_cnt_q, w_cnt_d;
    logic [LW-1:0] l_cnt_q, l_cnt_d;
    logic [KW-1:0] k_cnt_q, k_cnt_d;
    logic [KW-1:0] rd_kidx_q, rd_kidx_d;

    logic w_last, l_last, k_last, wr_fire;
    logic full0, full1, full_any, full_sel, other_sel, accept_ok;

    assign wr_fire   = wt.cfg_wren && busy_q;
    assign w_last    = desc_1x1_q[wr_ptr_q] ? (w_cnt_q == 4'd0) : (w_cnt_q == 4'd8);
    assign l_last    = (l_cnt_q == LW'(C_NUM_LANES - 1));
    assign k_last    = (k_cnt_q == desc_nk_q[wr_ptr_q]);

    // With both banks FULL the older load sits at wr_ptr, since it has toggled twice since then.
    assign full0     = (bank_q[0] == BANK_FULL);
    assign full1     = (bank_q[1] == BANK_FULL);
    assign full_any  = full0 || full1;
    assign full_sel  = (full0 && full1) ? wr_ptr_q : full1;
    assign other_sel = ~full_sel;
    assign accept_ok = wt.job_accept && full_any;

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_d[b]     = bank_q[b];
            desc_1x1_d[b] = desc_1x1_q[b];
            desc_nk_d[b]  = desc_nk_q[b];
        end
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        busy_d    = busy_q;
        err_d     = err_q;
        reject_d  = 1'b0;
        w_cnt_d   = w_cnt_q;
        l_cnt_d   = l_cnt_q;
        k_cnt_d   = k_cnt_q;
        rd_kidx_d = rd_kidx_q;

        if (wt.cfg_start) begin
            if (busy_q || (bank_q[wr_ptr_q] != BANK_EMPTY)) begin
                err_d = 1'b1;
            end else begin
                desc_1x1_d[wr_ptr_q] = wt.cfg_krnl_1x1;
                desc_nk_d[wr_ptr_q]  = wt.cfg_num_kernels;
                w_cnt_d              = 4'd0;
                l_cnt_d              = '0;
                k_cnt_d              = '0;
                bank_d[wr_ptr_q]     = BANK_LOADING;
                busy_d               = 1'b1;
            end
        end

        // Start is only accepted while idle and writes only land while busy, so the two never both steer the counters.
        if (wt.cfg_wren) begin
            if (!busy_q) begin
                err_d = 1'b1;
            end else if (!w_last) begin
                w_cnt_d = w_cnt_q + 4'd1;
            end else begin
                w_cnt_d = 4'd0;
                if (!l_last) begin
                    l_cnt_d = l_cnt_q + 1'b1;
                end else begin
                    l_cnt_d = '0;
                    if (!k_last) begin
                        k_cnt_d = k_cnt_q + 1'b1;
                    end else begin
                        k_cnt_d          = '0;
                        bank_d[wr_ptr_q] = BANK_FULL;
                        busy_d           = 1'b0;
                        wr_ptr_d         = ~wr_ptr_q;
                    end
                end
            end
        end

        if (wt.job_accept) begin
            if (full_any) begin
                if (bank_q[other_sel] == BANK_ACTIVE) begin
                    bank_d[other_sel] = BANK_EMPTY;
                end
                bank_d[full_sel] = BANK_ACTIVE;
                rd_ptr_d         = full_sel;
                rd_kidx_d        = '0;
            end else begin
                reject_d = 1'b1;
            end
        end

        if (wt.next_kernel && !accept_ok) begin
            rd_kidx_d = (rd_kidx_q == desc_nk_q[rd_ptr_q]) ? '0 : rd_kidx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b]     <= BANK_EMPTY;
                desc_1x1_q[b] <= 1'b0;
                desc_nk_q[b]  <= '0;
            end
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            reject_q  <= 1'b0;
            w_cnt_q   <= 4'd0;
            l_cnt_q   <= '0;
            k_cnt_q   <= '0;
            rd_kidx_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b]     <= bank_d[b];
                desc_1x1_q[b] <= desc_1x1_d[b];
                desc_nk_q[b]  <= desc_nk_d[b];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            reject_q  <= reject_d;
            w_cnt_q   <= w_cnt_d;
            l_cnt_q   <= l_cnt_d;
            k_cnt_q   <= k_cnt_d;
            rd_kidx_q <= rd_kidx_d;
        end
    end

    // Read request: address and kernel-match flag are captured with ce_execute, so in-flight reads keep their kernel.
    logic [AW-1:0] rd_addr_c [C_NUM_LANES];
    logic          rd_last_c;
    logic [AW-1:0] addr_dly_q [SD][C_NUM_LANES];
    logic [SD-1:0] re_dly_q;
    logic [SD-1:0] last_dly_q;

    always_comb begin
        for (int i = 0; i < C_NUM_LANES; i++) begin
            rd_addr_c[i] = {rd_ptr_q, rd_kidx_q, wt.seq_addr[4*i +: 4]};
        end
        rd_last_c = wt.ce_execute && (rd_kidx_q == desc_nk_q[rd_ptr_q]);
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SD; s++) begin
                for (int i = 0; i < C_NUM_LANES; i++) begin
                    addr_dly_q[s][i] <= '0;
                end
            end
            re_dly_q   <= '0;
            last_dly_q <= '0;
        end else begin
            for (int i = 0; i < C_NUM_LANES; i++) begin
                addr_dly_q[0][i] <= rd_addr_c[i];
            end
            for (int s = 1; s < SD; s++) begin
                for (int i = 0; i < C_NUM_LANES; i++) begin
                    addr_dly_q[s][i] <= addr_dly_q[s-1][i];
                end
            end
            re_dly_q[0]   <= wt.ce_execute;
            last_dly_q[0] <= rd_last_c;
            for (int s = 1; s < SD; s++) begin
                re_dly_q[s]   <= re_dly_q[s-1];
                last_dly_q[s] <= last_dly_q[s-1];
            end
        end
    end

    logic [AW-1:0] wr_addr;
    logic          ram_re;
    logic [DW-1:0] ram_rd_dat;

    assign wr_addr = {wr_ptr_q, k_cnt_q, w_cnt_q};
    assign ram_re  = re_dly_q[SD-1];

    for (genvar gi = 0; gi < C_NUM_LANES; gi++) begin : g_lane
        logic [C_WEIGHT_WIDTH-1:0] mem [DEPTH];
        logic [C_WEIGHT_WIDTH-1:0] ram_q;
        logic                      lane_we;

        assign lane_we = wr_fire && (l_cnt_q == LW'(gi));

        always_ff @(posedge clk_core) begin
            if (lane_we) begin
                mem[wr_addr] <= wt.cfg_data;
            end
            if (ram_re) begin
                ram_q <= mem[addr_dly_q[SD-1][gi]];
            end
        end

        assign ram_rd_dat[gi*C_WEIGHT_WIDTH +: C_WEIGHT_WIDTH] = ram_q;
    end

    // Output register chain; data stages only load behind a valid beat, valid/last are flushed by rst.
    logic [RL-1:0] rv_q;
    logic [RL-1:0] lv_q;
    logic [DW-1:0] out_q [RL-1];

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            rv_q <= '0;
            lv_q <= '0;
            for (int s = 0; s < RL - 1; s++) begin
                out_q[s] <= '0;
            end
        end else begin
            rv_q[0] <= ram_re;
            lv_q[0] <= last_dly_q[SD-1];
            for (int s = 1; s < RL; s++) begin
                rv_q[s] <= rv_q[s-1];
                lv_q[s] <= lv_q[s-1];
            end
            if (rv_q[0]) begin
                out_q[0] <= ram_rd_dat;
            end
            for (int s = 1; s < RL - 1; s++) begin
                if (rv_q[s]) begin
                    out_q[s] <= out_q[s-1];
                end
            end
        end
    end

    assign wt.cfg_busy       = busy_q;
    assign wt.cfg_err        = err_q;
    assign wt.bank_full      = {bank_q[1] == BANK_FULL, bank_q[0] == BANK_FULL};
    assign wt.job_reject     = reject_q;
    assign wt.wht_dout       = out_q[RL-2];
    assign wt.wht_dout_valid = rv_q[RL-1];
    assign wt.last_kernel    = lv_q[RL-1];
endmodule
